// File: rtl/cbus_axi_bridge_pkg.sv
// Shared widths and cbus request/response payloads for the cbus-to-AXI bridge.

package cbus_axi_bridge_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = 4;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned AXI_LEN_W = 8;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned BURST_W   = 2;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// Serialises one granted cbus burst at a time onto AXI4 AR/R or AW/W/B and
// returns per-beat ready/last to the arbiter.

module cbus_axi_bridge
    import cbus_axi_bridge_pkg::*;
#(
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  cbus_req_t            creq,
    output cbus_resp_t           cresp,
    output logic [ID_WIDTH-1:0]  arid,
    output logic [ADDR_W-1:0]    araddr,
    output logic [AXI_LEN_W-1:0] arlen,
    output logic [SIZE_W-1:0]    arsize,
    output logic [BURST_W-1:0]   arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_WIDTH-1:0]  rid,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [RESP_W-1:0]    rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ID_WIDTH-1:0]  awid,
    output logic [ADDR_W-1:0]    awaddr,
    output logic [AXI_LEN_W-1:0] awlen,
    output logic [SIZE_W-1:0]    awsize,
    output logic [BURST_W-1:0]   awburst,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_W-1:0]    wdata,
    output logic [STRB_W-1:0]    wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [ID_WIDTH-1:0]  bid,
    input  logic [RESP_W-1:0]    bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [LEN_W-1:0]    len_q, len_d;

    // Response IDs and error codes are deliberately dropped.
    logic unused_axi;
    assign unused_axi = ^{rid, rresp, bid, bresp};

    assign arid    = ID_WIDTH'(AXI_ID);
    assign awid    = ID_WIDTH'(AXI_ID);
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arlen   = {4'b0000, len_q};
    assign awlen   = {4'b0000, len_q};
    assign arsize  = size_q;
    assign awsize  = size_q;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            len_q   <= len_d;
        end
    end

    // Next-state and handshake decode; every output depends only on state and AXI/creq inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        len_d   = len_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;
        cresp   = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (creq.valid) begin
                    addr_d  = creq.addr;
                    size_d  = creq.size;
                    len_d   = creq.len;
                    state_d = creq.is_write ? AW : AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_d = R;
            end
            R: begin
                rready      = 1'b1;
                cresp.ready = rvalid;
                cresp.data  = rdata;
                cresp.last  = rvalid & rlast;
                if (rvalid && rlast) state_d = IDLE;
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_d = W;
            end
            W: begin
                wvalid      = 1'b1;
                wdata       = creq.data;
                wstrb       = creq.strobe;
                wlast       = (cnt_q == len_q);
                cresp.ready = wready;
                // Holding on the final beat keeps the counter from wrapping at len=15.
                if (wready) begin
                    if (wlast) state_d = B;
                    else       cnt_d   = cnt_q + LEN_W'(1);
                end
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    cresp.last = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Self-checking bench for cbus_axi_bridge: table of bursts driven through an
// AXI slave model with a scoreboard, plus back-to-back and mid-burst reset cases.

module tb_cbus_axi_bridge;
    import cbus_axi_bridge_pkg::*;

    logic         clk;
    logic         resetn;
    cbus_req_t    creq;
    cbus_resp_t   cresp;
    logic [3:0]   arid, rid, awid, bid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    cbus_axi_bridge #(.AXI_ID(0), .ID_WIDTH(4)) dut (
        .clk(clk), .resetn(resetn), .creq(creq), .cresp(cresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [15:0] stall;      // bit i set: slave withholds valid/ready in data cycle i
        int unsigned hs_dly;     // cycles arready/awready is held low
        int unsigned b_dly;
        logic [31:0] first_data;
        logic [7:0]  exp_len;
        int unsigned exp_beats;
        int unsigned exp_first;  // read: cycle index (AR cycle = 0) of first cresp.ready
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } sb_t;

    sb_t         q[$];
    vec_t        vecs[6];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit stalled(input logic [15:0] s, input int unsigned i);
        return (i < 16) ? s[4'(i)] : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        creq.valid = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            chk("idle_ctrl_zero", 64'({arvalid, awvalid, wvalid, wlast, rready, bready,
                                       cresp.ready, cresp.last}), 64'd0);
            chk("idle_cresp_data", 64'(cresp.data), 64'd0);
            tick();
        end
    endtask

    task automatic do_read(input vec_t v);
        int unsigned cyc, ar_cnt, didx, sent, beats, first;
        bit data_ph, done, got_first;
        sb_t e;
        cyc = 0; ar_cnt = 0; didx = 0; sent = 0; beats = 0; first = 0;
        data_ph = 1'b0; done = 1'b0; got_first = 1'b0;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr = v.addr;
        creq.len = v.len;
        creq.size = v.size;
        creq.data = $urandom;
        creq.strobe = 4'($urandom);
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        chk("rd_idle_cycle", 64'({arvalid, awvalid, cresp.ready}), 64'd0);
        tick();
        while (!done && cyc < 200) begin
            if (!data_ph) begin
                arready = (ar_cnt >= v.hs_dly);
            end else begin
                arready = 1'b0;
                rvalid = !stalled(v.stall, didx);
                rdata = (sent == 0) ? v.first_data : $urandom;
                rlast = rvalid && (sent == 32'(v.len));
                rid = 4'($urandom);
                rresp = 2'($urandom);
                if (rvalid) begin
                    e = '{rdata, 4'h0, rlast};
                    q.push_back(e);
                    sent++;
                end
            end
            @(negedge clk);
            chk("rd_no_awvalid", 64'(awvalid), 64'd0);
            if (!data_ph) begin
                if (cyc == 0) chk("rd_arvalid_rise", 64'(arvalid), 64'd1);
                chk("rd_ar_no_rready", 64'(rready), 64'd0);
                if (arvalid && arready) begin
                    chk("rd_araddr", 64'(araddr), 64'(v.addr));
                    chk("rd_arlen", 64'(arlen), 64'(v.exp_len));
                    chk("rd_arsize", 64'(arsize), 64'(v.size));
                    chk("rd_arburst", 64'(arburst), 64'd1);
                    chk("rd_arid", 64'(arid), 64'd0);
                    chk("rd_ar_hold", 64'(ar_cnt), 64'(v.hs_dly));
                    data_ph = 1'b1;
                end
                ar_cnt++;
            end else begin
                chk("rd_rready", 64'(rready), 64'd1);
                chk("rd_ready_vs_rvalid", 64'(cresp.ready), 64'(rvalid));
                if (cresp.ready) begin
                    chk("rd_sb_nonempty", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("rd_data", 64'(cresp.data), 64'(e.data));
                        chk("rd_last", 64'(cresp.last), 64'(e.last));
                    end
                    beats++;
                    if (!got_first) begin
                        first = cyc;
                        got_first = 1'b1;
                    end
                end else begin
                    chk("rd_last_without_ready", 64'(cresp.last), 64'd0);
                end
                if (rvalid && rlast) done = 1'b1;
                didx++;
            end
            cyc++;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
        chk("rd_completed", 64'(done), 64'd1);
        chk("rd_beats", 64'(beats), 64'(v.exp_beats));
        chk("rd_first_latency", 64'(first), 64'(v.exp_first));
        chk("rd_sb_drained", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic do_write(input vec_t v);
        logic [31:0] words [16];
        logic [3:0]  strbs [16];
        int unsigned cyc, aw_cnt, b_cnt, didx, acc, pushed;
        int ph;
        bit done;
        sb_t e;
        cyc = 0; aw_cnt = 0; b_cnt = 0; didx = 0; acc = 0; pushed = 0;
        ph = 0; done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            strbs[i] = 4'($urandom);
        end
        creq = '0;
        creq.valid = 1'b1;
        creq.is_write = 1'b1;
        creq.addr = v.addr;
        creq.len = v.len;
        creq.size = v.size;
        creq.data = words[0];
        creq.strobe = strbs[0];
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        chk("wr_idle_cycle", 64'({arvalid, awvalid, wvalid, cresp.ready}), 64'd0);
        tick();
        while (!done && cyc < 200) begin
            awready = (ph == 0) && (aw_cnt >= v.hs_dly);
            wready = (ph == 1) && !stalled(v.stall, didx);
            bvalid = (ph == 2) && (b_cnt >= v.b_dly);
            bid = 4'($urandom);
            bresp = 2'($urandom);
            if (acc < 16) begin
                creq.data = words[4'(acc)];
                creq.strobe = strbs[4'(acc)];
                if (ph == 1 && pushed == acc) begin
                    e = '{words[4'(acc)], strbs[4'(acc)], acc == 32'(v.len)};
                    q.push_back(e);
                    pushed++;
                end
            end
            @(negedge clk);
            chk("wr_no_arvalid", 64'(arvalid), 64'd0);
            case (ph)
                0: begin
                    chk("wr_awvalid_held", 64'(awvalid), 64'd1);
                    chk("wr_no_early_wvalid", 64'(wvalid), 64'd0);
                    chk("wr_awaddr_stable", 64'(awaddr), 64'(v.addr));
                    if (awvalid && awready) begin
                        chk("wr_awlen", 64'(awlen), 64'(v.exp_len));
                        chk("wr_awsize", 64'(awsize), 64'(v.size));
                        chk("wr_awburst", 64'(awburst), 64'd1);
                        chk("wr_awid", 64'(awid), 64'd0);
                        chk("wr_aw_hold", 64'(aw_cnt), 64'(v.hs_dly));
                        ph = 1;
                    end
                    aw_cnt++;
                end
                1: begin
                    chk("wr_wvalid", 64'(wvalid), 64'd1);
                    chk("wr_wdata_track", 64'(wdata), 64'(creq.data));
                    chk("wr_wlast_pos", 64'(wlast), 64'(acc == 32'(v.len)));
                    chk("wr_ready_vs_wready", 64'(cresp.ready), 64'(wready));
                    chk("wr_no_last", 64'(cresp.last), 64'd0);
                    if (wvalid && wready) begin
                        chk("wr_sb_nonempty", 64'(q.size() != 0), 64'd1);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            chk("wr_data", 64'(wdata), 64'(e.data));
                            chk("wr_strb", 64'(wstrb), 64'(e.strb));
                            chk("wr_wlast", 64'(wlast), 64'(e.last));
                            if (e.last) ph = 2;
                        end
                        acc++;
                    end
                    didx++;
                end
                default: begin
                    chk("wr_bready", 64'(bready), 64'd1);
                    chk("wr_b_no_wvalid", 64'(wvalid), 64'd0);
                    if (bvalid) begin
                        chk("wr_b_last_pulse", 64'(cresp.last), 64'd1);
                        chk("wr_b_no_ready", 64'(cresp.ready), 64'd0);
                        done = 1'b1;
                    end else begin
                        chk("wr_b_wait_no_last", 64'(cresp.last), 64'd0);
                    end
                    b_cnt++;
                end
            endcase
            cyc++;
            tick();
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        chk("wr_completed", 64'(done), 64'd1);
        chk("wr_beats", 64'(acc), 64'(v.exp_beats));
        chk("wr_sb_drained", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_write) do_write(v);
        else            do_read(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //         wr    addr          len  size stall     hs b  first_data    len  beats first
        vecs[0] = '{1'b0, 32'h1000_0000, 4'd0,  3'd2, 16'h0000, 0, 0, 32'hDEAD_BEEF, 8'd0,  1,  1};
        vecs[1] = '{1'b0, 32'h2000_0040, 4'd3,  3'd2, 16'h0012, 0, 0, 32'h0123_4567, 8'd3,  4,  1};
        vecs[2] = '{1'b1, 32'h3000_0000, 4'd15, 3'd2, 16'h0180, 0, 1, 32'h0,         8'd15, 16, 0};
        vecs[3] = '{1'b1, 32'h4000_0100, 4'd0,  3'd2, 16'h0000, 5, 0, 32'h0,         8'd0,  1,  0};
        vecs[4] = '{1'b0, 32'h5000_0000, 4'd7,  3'd1, 16'h0001, 2, 0, 32'hCAFE_F00D, 8'd7,  8,  4};
        vecs[5] = '{1'b1, 32'h6000_0200, 4'd3,  3'd2, 16'h0005, 1, 3, 32'h0,         8'd3,  4,  0};

        resetn = 1'b0;
        creq = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        #2;
        chk("reset_ctrl_zero", 64'({arvalid, awvalid, wvalid, wlast, rready, bready,
                                    cresp.ready, cresp.last}), 64'd0);
        chk("reset_araddr", 64'(araddr), 64'd0);
        chk("reset_awlen", 64'(awlen), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        idle(2);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            idle(1);
        end

        // Back-to-back read then write with creq.valid never dropped.
        do_read(vecs[1]);
        do_write(vecs[5]);
        idle(1);

        // Reset during beat 2 of a 4-beat write.
        creq = '0;
        creq.valid = 1'b1;
        creq.is_write = 1'b1;
        creq.addr = 32'h7000_0000;
        creq.len = 4'd3;
        creq.size = 3'd2;
        creq.data = 32'hA5A5_0001;
        creq.strobe = 4'hF;
        awready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_seq_awvalid", 64'(awvalid), 64'd1);
        tick();
        awready = 1'b0;
        wready = 1'b1;
        @(negedge clk);
        chk("rst_seq_beat1", 64'(wdata), 64'h0000_0000_A5A5_0001);
        tick();
        creq.data = 32'hA5A5_0002;
        @(negedge clk);
        chk("rst_seq_beat2", 64'({wvalid, wlast, wdata}), 64'({1'b1, 1'b0, 32'hA5A5_0002}));
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_w_zero", 64'({arvalid, awvalid, wvalid, wlast, rready, bready,
                                   cresp.ready, cresp.last}), 64'd0);
        wready = 1'b0;
        creq = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        idle(2);
        do_read(vecs[4]);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
